// File: rtl/ikaopll_eg_state_ctrl_pkg.sv
// Shared definitions for the OPLL envelope phase sequencer: phase encodings,
// slot count and the layout of one circular-storage entry.
package ikaopll_eg_state_ctrl_pkg;
  localparam int SLOTS  = 18;
  localparam int SLOT_W = 5;

  typedef enum logic [1:0] {
    EG_ATTACK  = 2'd0,
    EG_DECAY   = 2'd1,
    EG_SUSTAIN = 2'd2,
    EG_RELEASE = 2'd3
  } eg_phase_e;

  typedef struct packed {
    eg_phase_e phase;
    logic      kon_prev;
  } eg_entry_t;
endpackage

// File: rtl/ikaopll_eg_state_ctrl_if.sv
// Slot-rate bundle between the operator sequencer, the phase sequencer and the
// EG datapath. The master drives the per-slot inputs; the slave reports the phase.
interface ikaopll_eg_state_ctrl_if #(
  parameter int SLOT_W = ikaopll_eg_state_ctrl_pkg::SLOT_W
);
  logic              phi1_ncen_n;
  logic              cycle_00;
  logic              kon;
  logic              atten_zero;
  logic              atten_ge_sl;
  logic              test_freeze;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        envstat;
  logic              eg_restart;

  modport master (
    output phi1_ncen_n, cycle_00, kon, atten_zero, atten_ge_sl, test_freeze,
    input  slot, envstat, eg_restart
  );

  modport slave (
    input  phi1_ncen_n, cycle_00, kon, atten_zero, atten_ge_sl, test_freeze,
    output slot, envstat, eg_restart
  );
endinterface

// File: rtl/ikaopll_eg_slot_sr.sv
// Circular per-slot storage: the head is the slot being processed, the
// updated entry enters at the tail, and a synchronous clear resets every entry.
module ikaopll_eg_slot_sr #(
  parameter int DEPTH = ikaopll_eg_state_ctrl_pkg::SLOTS
) (
  input  logic                                 clk,
  input  logic                                 clr_n,
  input  logic                                 shift,
  input  ikaopll_eg_state_ctrl_pkg::eg_entry_t din,
  output ikaopll_eg_state_ctrl_pkg::eg_entry_t head
);
  import ikaopll_eg_state_ctrl_pkg::*;

  eg_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{phase: EG_RELEASE, kon_prev: 1'b0};
    end else if (shift) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i + 1];
      mem[DEPTH - 1] <= din;
    end
  end

  assign head = mem[0];
endmodule

// File: rtl/ikaopll_eg_state_ctrl.sv
// Per-operator envelope phase sequencer: walks the 18 slots, presents each
// slot's phase and decides its next phase from key-on edges and attenuation flags.
module ikaopll_eg_state_ctrl #(
  parameter int SLOTS  = 18,
  parameter int SLOT_W = 5
) (
  input logic                     i_EMUCLK,
  input logic                     i_IC_n,
  ikaopll_eg_state_ctrl_if.slave  eg
);
  import ikaopll_eg_state_ctrl_pkg::*;

  logic              adv;
  eg_entry_t         head;
  eg_entry_t         tail_d;
  logic              restart_d;
  logic [SLOT_W-1:0] slot_q;
  logic              restart_q;

  assign adv = ~eg.phi1_ncen_n;

  // Priority order matters: a key-on edge outranks the attenuation flags, and
  // only one transition is taken per visit.
  always_comb begin
    tail_d    = head;
    restart_d = 1'b0;
    if (!eg.test_freeze) begin
      tail_d.kon_prev = eg.kon;
      if (eg.kon && !head.kon_prev) begin
        tail_d.phase = EG_ATTACK;
        restart_d    = 1'b1;
      end else if (!eg.kon && head.kon_prev) begin
        tail_d.phase = EG_RELEASE;
      end else if (head.phase == EG_ATTACK && eg.atten_zero) begin
        tail_d.phase = EG_DECAY;
      end else if (head.phase == EG_DECAY && eg.atten_ge_sl) begin
        tail_d.phase = EG_SUSTAIN;
      end
    end
  end

  ikaopll_eg_slot_sr #(.DEPTH(SLOTS)) u_slot_sr (
    .clk   (i_EMUCLK),
    .clr_n (i_IC_n),
    .shift (adv),
    .din   (tail_d),
    .head  (head)
  );

  // cycle_00 only relabels the counter; storage keeps its own rotation.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      slot_q    <= '0;
      restart_q <= 1'b0;
    end else if (adv) begin
      if (eg.cycle_00 || slot_q == SLOT_W'(SLOTS - 1)) slot_q <= '0;
      else                                            slot_q <= slot_q + SLOT_W'(1);
      restart_q <= restart_d;
    end
  end

  assign eg.slot       = slot_q;
  assign eg.envstat    = head.phase;
  assign eg.eg_restart = restart_q;
endmodule
